stage_wb_trace: RTL
===================

Name: stage_wb_trace

Overview:
- Parametrised multi-lane writing-back stage for the turbo RISC-V pipeline.
- Generates regfile write enables for LANES retiring instructions per cycle.
- Buffers retire records in a multi-push, single-pop trace FIFO. The trace consumer drains it with a valid/ready handshake.
- Backpressures the pipeline when the FIFO cannot accept a full retire group.

Parameters:
LANES, 2, retire lanes per cycle (1..4); lane 0 is oldest in program order
XLEN, 32, data/PC width
RF_AW, 5, regfile address width
DEPTH, 8, trace FIFO entries; power of two, >= 2*LANES
TW, 1+RF_AW+2*XLEN, trace record width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
done_i  in  LANES  lane k holds a completing instruction
pc_i  in  LANES*XLEN  lane k PC at [k*XLEN +: XLEN]
rf_waddr_i  in  LANES*RF_AW  per-lane destination register
rf_wdata_i  in  LANES*XLEN  per-lane write data
rf_wen_o  out  LANES  per-lane regfile write enable; regfile uses rf_waddr_i/rf_wdata_i directly
wb_stall_o  out  1  FIFO free slots < LANES
trace_valid_o  out  1  head record available
trace_ready_i  in  1  consumer accepts head
trace_data_o  out  TW  head record {wen, waddr, wdata, pc}, MSB first
drop_cnt_o  out  16  saturating count of records lost to overflow

Behaviour:
- Reset (resetn low, async): FIFO empty; head/tail/count = 0; drop_cnt_o = 0; retire counter = 0.
- Outputs during reset: trace_valid_o = 0, wb_stall_o = 0, trace_data_o = 0. rf_wen_o is combinational and still follows done_i.
- rf_wen_o[k] = done_i[k] && waddr[k] != 0 && no younger lane j>k with the same condition writes the same waddr. Youngest writer wins; the older write is suppressed.
- Trace record for each done lane: {rf_wen_o[k], waddr[k], wdata[k], pc[k]}. A suppressed write appears with wen = 0.
- Records are pushed in lane order, lowest index first, compacted (lanes with done_i = 0 skipped), all on the same cycle edge.
- Pop: one record per cycle when trace_valid_o && trace_ready_i. A pop frees its slot for the same-edge push computation (free = DEPTH - count + pop).
- trace_valid_o = (count != 0), registered-state derived. trace_data_o is the head entry, stable while valid and not popped.
- wb_stall_o = (DEPTH - count) < LANES, from registered count only, so there is no combinational path from done_i.
  - Upstream must hold done_i = 0 while stalled.
- Overflow: if pushes exceed free slots anyway, the oldest lanes that fit are stored and the excess is dropped.
  - drop_cnt_o += dropped records, saturating at 16'hFFFF.
  - rf_wen_o is unaffected by overflow; architectural state never depends on the trace.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH inclusive (clog2(DEPTH)+1 bits).
- Simultaneous push and pop on an empty FIFO: the pushed record becomes visible next cycle; no same-cycle bypass.
- Latency: done_i to trace_valid_o is 1 cycle.
- Reset mid-operation: all buffered records are discarded; no partial pops.

Optional Feature:
- RETIRE_CNT_EN defined:
  - Adds output retire_cnt_o [63:0], incremented by popcount(done_i) each cycle, wrapping at 2^64.
  - Counts every completing instruction, including dropped ones.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - record field offsets (TRC_PC_LSB, TRC_WDATA_LSB, TRC_WADDR_LSB, TRC_WEN_BIT)
  - function tw(rf_aw, xlen)
  - a LANES-bit popcount function
- Sub-module trace_fifo_mpush: parametrised N-push/1-pop circular buffer with count, free and drop outputs. The top level keeps the write-enable resolution and record packing.

Test Plan:
- Single lane, LANES=2: lane0 done, waddr=5, wdata=0x1234, pc=0x80000000 -> rf_wen_o=2'b01; next cycle trace_data_o={1,5,0x1234,0x80000000}, trace_valid_o=1.
- Same-register conflict: both lanes waddr=7, wdata 0xA/0xB -> rf_wen_o=2'b10; two records, lane0 with wen=0 first.
- x0 write: lane1 done, waddr=0 -> rf_wen_o[1]=0; record wen=0 still pushed.
- Fill: trace_ready_i=0, push 2/cycle with DEPTH=8 -> wb_stall_o rises when count=7 or 8 (free < 2); force 2 more pushes at count=7 -> 1 stored, drop_cnt_o=1.
- Drain with simultaneous push at count=7: pop + 2 pushes -> count=8, no drop; FIFO order preserved across pointer wrap.
- Async reset asserted mid-drain, with RETIRE_CNT_EN defined -> trace_valid_o=0, drop_cnt_o=0 and retire_cnt_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/trace stage: trace record layout and small helpers.
// Records are {wen, waddr, wdata, pc}, MSB first; the pc field sits at bit 0.
package wb_pkg;

  localparam int MAX_LANES  = 4;
  localparam int TRC_PC_LSB = 0;

  function automatic int tw(input int rf_aw, input int xlen);
    return 1 + rf_aw + 2 * xlen;
  endfunction

  function automatic int trc_wdata_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int trc_waddr_lsb(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int trc_wen_bit(input int rf_aw, input int xlen);
    return 2 * xlen + rf_aw;
  endfunction

  function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/trace_fifo_mpush.sv
// N-push / 1-pop circular buffer; valid lanes are compacted in lane order and pushes beyond the
// free space (which includes a same-edge pop) are dropped. Push data is visible one cycle later.
module trace_fifo_mpush #(
  parameter int N     = 2,
  parameter int W     = 70,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   push_vld_i,
  input  logic [N*W-1:0] push_dat_i,
  input  logic           pop_i,
  output logic [W-1:0]   head_dat_o,
  output logic [CW-1:0]  count_o,
  output logic [CW-1:0]  free_o,
  output logic [CW-1:0]  drop_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] head_d, tail_d;
  logic [CW-1:0] count_d;

  logic          pop_fire;
  logic [CW-1:0] push_free;
  logic [CW-1:0] n_push, n_store;
  logic [N-1:0]  wr_en;
  logic [AW-1:0] wr_ptr [N];

  assign pop_fire  = pop_i && (count_q != '0);
  assign push_free = CW'(DEPTH) - count_q + CW'(pop_fire);

  // Each valid lane takes the next tail slot; lanes past the free space are counted as drops.
  always_comb begin
    n_push  = '0;
    n_store = '0;
    for (int k = 0; k < N; k++) begin
      wr_en[k]  = 1'b0;
      wr_ptr[k] = '0;
      if (push_vld_i[k]) begin
        if (n_push < push_free) begin
          wr_en[k]  = 1'b1;
          wr_ptr[k] = tail_q + AW'(n_push);
          n_store   = n_store + 1'b1;
        end
        n_push = n_push + 1'b1;
      end
    end
  end

  assign head_d  = head_q + AW'(pop_fire);
  assign tail_d  = tail_q + AW'(n_store);
  assign count_d = count_q + n_store - CW'(pop_fire);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wr_en[k]) mem_q[wr_ptr[k]] <= push_dat_i[k*W +: W];
    end
  end

  // Gating on count keeps the head at zero while empty, including throughout reset.
  assign head_dat_o = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o    = count_q;
  assign free_o     = CW'(DEPTH) - count_q;
  assign drop_o     = n_push - n_store;

endmodule

// File: rtl/stage_wb_trace.sv
// Multi-lane writeback: youngest-writer-wins regfile enables, 1-cycle trace FIFO, stall when free < LANES.
// Optional RETIRE_CNT_EN adds a 64-bit retired-instruction counter on retire_cnt_o.
module stage_wb_trace
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [LANES-1:0]             done_i,
  input  logic [LANES*XLEN-1:0]        pc_i,
  input  logic [LANES*RF_AW-1:0]       rf_waddr_i,
  input  logic [LANES*XLEN-1:0]        rf_wdata_i,
  output logic [LANES-1:0]             rf_wen_o,
  output logic                         wb_stall_o,
  output logic                         trace_valid_o,
  input  logic                         trace_ready_i,
  output logic [tw(RF_AW, XLEN)-1:0]   trace_data_o,
  output logic [15:0]                  drop_cnt_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]                  retire_cnt_o
`endif
);

  localparam int TW            = tw(RF_AW, XLEN);
  localparam int CW            = $clog2(DEPTH) + 1;
  localparam int TRC_WDATA_LSB = trc_wdata_lsb(XLEN);
  localparam int TRC_WADDR_LSB = trc_waddr_lsb(XLEN);
  localparam int TRC_WEN_BIT   = trc_wen_bit(RF_AW, XLEN);

  logic [LANES*TW-1:0] push_dat;
  logic [CW-1:0]       fifo_count, fifo_free, fifo_drop;
  logic [15:0]         drop_q, drop_d;
  logic [16:0]         drop_sum;

  // A lane loses its write when any younger completing lane targets the same nonzero register.
  always_comb begin
    rf_wen_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (done_i[k] && (rf_waddr_i[k*RF_AW +: RF_AW] != '0)) begin
        rf_wen_o[k] = 1'b1;
        for (int j = k + 1; j < LANES; j++) begin
          if (done_i[j] && (rf_waddr_i[j*RF_AW +: RF_AW] == rf_waddr_i[k*RF_AW +: RF_AW]))
            rf_wen_o[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    push_dat = '0;
    for (int k = 0; k < LANES; k++) begin
      push_dat[k*TW + TRC_PC_LSB    +: XLEN]  = pc_i[k*XLEN +: XLEN];
      push_dat[k*TW + TRC_WDATA_LSB +: XLEN]  = rf_wdata_i[k*XLEN +: XLEN];
      push_dat[k*TW + TRC_WADDR_LSB +: RF_AW] = rf_waddr_i[k*RF_AW +: RF_AW];
      push_dat[k*TW + TRC_WEN_BIT]            = rf_wen_o[k];
    end
  end

  trace_fifo_mpush #(
    .N     (LANES),
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_vld_i (done_i),
    .push_dat_i (push_dat),
    .pop_i      (trace_ready_i),
    .head_dat_o (trace_data_o),
    .count_o    (fifo_count),
    .free_o     (fifo_free),
    .drop_o     (fifo_drop)
  );

  assign trace_valid_o = (fifo_count != '0);
  assign wb_stall_o    = (fifo_free < CW'(LANES));

  assign drop_sum = {1'b0, drop_q} + 17'(fifo_drop);
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;

`ifdef RETIRE_CNT_EN
  logic [63:0] retire_q, retire_d;

  assign retire_d = retire_q + 64'(popcount(MAX_LANES'(done_i)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) retire_q <= '0;
    else         retire_q <= retire_d;
  end

  assign retire_cnt_o = retire_q;
`endif

endmodule
